// File: rtl/escalonador_tiros.sv
// Every PERIODO cycles, pick a live enemy (nearest row first) and launch it into the lowest free shot slot; pulse 3 + cells scanned cycles after leaving ESPERA.
// No backpressure: with no free slot the attempt is dropped and counted. ESCALONADOR_RR_EN selects a round-robin start column instead of the LFSR.
module escalonador_tiros #(
    parameter int LINHAS  = 5,
    parameter int COLUNAS = 8,
    parameter int N_TIROS = 4,
    parameter int PERIODO = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LINHAS*COLUNAS-1:0]   enemy_vivos,
    input  logic [1:0]                  estado_jogo,
    input  logic [N_TIROS-1:0]          tiro_livre,
    output logic [N_TIROS-1:0]          disparo,
    output logic [5:0]                  tiro_X,
    output logic [5:0]                  tiro_Y,
    output logic                        ocupado,
    output logic [15:0]                 descartes
);

    localparam int CW = $clog2(PERIODO);
    localparam int NC = LINHAS * COLUNAS;

    typedef enum logic [2:0] {ESPERA, SORTEIA, BUSCA, ALOCA, DISPARA} estado_t;

    estado_t          estado, prox;
    logic [CW-1:0]    contador;
    logic [15:0]      lfsr;
    logic [5:0]       coluna, linha, coluna_ini, coluna_seg;
    logic [6:0]       tentativas;
    logic [2:0]       slot, slot_livre;
    logic             algum_livre, celula_viva, rodando, fim_periodo;
    logic [11:0]      celula_idx;
    logic [NC-1:0]    vivos_desl;

    always_comb begin
        rodando     = (estado_jogo == 2'd1);
        fim_periodo = (contador == CW'(PERIODO - 1));
        celula_idx  = 12'(linha) * 12'(COLUNAS) + 12'(coluna);
        vivos_desl  = enemy_vivos >> celula_idx;
        celula_viva = vivos_desl[0];
        coluna_seg  = (coluna == 6'(COLUNAS - 1)) ? 6'd0 : coluna + 6'd1;
        slot_livre  = '0;
        algum_livre = 1'b0;
        // Descending scan so the lowest free index wins.
        for (int s = N_TIROS - 1; s >= 0; s--) begin
            if (tiro_livre[s]) begin
                slot_livre  = 3'(s);
                algum_livre = 1'b1;
            end
        end
    end

`ifdef ESCALONADOR_RR_EN
    logic [5:0] rr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (estado == DISPARA)
            rr_ptr <= (rr_ptr == 6'(COLUNAS - 1)) ? 6'd0 : rr_ptr + 6'd1;
    end

    assign coluna_ini = rr_ptr;
`else
    assign coluna_ini = 6'(lfsr % 16'(COLUNAS));
`endif

    // Fibonacci LFSR, taps 16/14/13/11 in right-shift form; free-running regardless of game state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            estado <= ESPERA;
        else
            estado <= prox;
    end

    always_comb begin
        prox    = estado;
        ocupado = (estado != ESPERA);
        disparo = '0;
        case (estado)
            ESPERA:  if (fim_periodo) prox = SORTEIA;
            SORTEIA: prox = BUSCA;
            BUSCA: begin
                if (celula_viva)
                    prox = ALOCA;
                else if (linha == 6'd0 && tentativas == 7'(COLUNAS - 1))
                    prox = ESPERA;
            end
            ALOCA:   prox = algum_livre ? DISPARA : ESPERA;
            DISPARA: begin
                prox = ESPERA;
                for (int s = 0; s < N_TIROS; s++)
                    disparo[s] = (slot == 3'(s));
            end
            default: prox = ESPERA;
        endcase
        if (!rodando)
            prox = ESPERA;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contador   <= '0;
            coluna     <= '0;
            linha      <= '0;
            tentativas <= '0;
            slot       <= '0;
            tiro_X     <= '0;
            tiro_Y     <= '0;
            descartes  <= '0;
        end else if (!rodando) begin
            contador <= '0;
        end else begin
            case (estado)
                ESPERA:  contador <= fim_periodo ? '0 : contador + 1'b1;
                SORTEIA: begin
                    coluna     <= coluna_ini;
                    linha      <= 6'(LINHAS - 1);
                    tentativas <= '0;
                end
                BUSCA: begin
                    // A live cell leaves coluna/linha untouched, which latches the shooter.
                    if (!celula_viva) begin
                        if (linha == 6'd0) begin
                            coluna     <= coluna_seg;
                            linha      <= 6'(LINHAS - 1);
                            tentativas <= tentativas + 7'd1;
                        end else begin
                            linha <= linha - 6'd1;
                        end
                    end
                end
                ALOCA: begin
                    if (algum_livre) begin
                        slot   <= slot_livre;
                        tiro_X <= coluna;
                        tiro_Y <= linha;
                    end else if (descartes != 16'hFFFF) begin
                        descartes <= descartes + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_tiros.sv
// Randomized bench for escalonador_tiros with a search-order reference model (LINHAS=4, COLUNAS=8, N_TIROS=2, PERIODO=16).
module tb_escalonador_tiros;

    localparam int L  = 4;
    localparam int C  = 8;
    localparam int NT = 2;
    localparam int P  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [L*C-1:0]  enemy_vivos;
    logic [1:0]      estado_jogo;
    logic [NT-1:0]   tiro_livre;
    logic [NT-1:0]   disparo;
    logic [5:0]      tiro_X, tiro_Y;
    logic            ocupado;
    logic [15:0]     descartes;

    int checks = 0;
    int errors = 0;
    int desc_m = 0;
    int rr_m   = 0;
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    escalonador_tiros #(.LINHAS(L), .COLUNAS(C), .N_TIROS(NT), .PERIODO(P)) dut (
        .clk(clk), .reset(reset), .enemy_vivos(enemy_vivos), .estado_jogo(estado_jogo),
        .tiro_livre(tiro_livre), .disparo(disparo), .tiro_X(tiro_X), .tiro_Y(tiro_Y),
        .ocupado(ocupado), .descartes(descartes)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        int v, b;
        v = int'(x);
        b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (b << 15));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_m <= 16'hACE1;
        else        lfsr_m <= lfsr_next(lfsr_m);
    end

    // Search order: start column, rows bottom (nearest player) to top, then next column, wrapping.
    function automatic void predict(input int start, input logic [31:0] viv,
                                    output bit found, output int x, output int y, output int cells);
        found = 0; x = 0; y = 0; cells = 0;
        for (int t = 0; t < C && !found; t++) begin
            for (int r = L - 1; r >= 0 && !found; r--) begin
                cells++;
                if (((viv >> (r * C + (start + t) % C)) & 32'd1) != 0) begin
                    found = 1; x = (start + t) % C; y = r;
                end
            end
        end
    endfunction

    function automatic logic [1:0] first_free(input logic [1:0] f);
        if (f[0]) return 2'b01;
        if (f[1]) return 2'b10;
        return 2'b00;
    endfunction

    // Entered at a falling edge; measures idle gap, busy length and the launch of one attempt.
    task automatic observe(output int gap, output int lat, output logic [1:0] pulse,
                           output int px, output int py, output int start, output bit bad);
        gap = 0; lat = 0; pulse = '0; px = 0; py = 0; start = 0; bad = 0;
        while (!ocupado && gap < 200) begin
            if (disparo != 0) bad = 1;
            gap++;
            @(negedge clk);
        end
        if (!ocupado) return;
`ifdef ESCALONADOR_RR_EN
        start = rr_m;
`else
        start = int'(lfsr_m) % C;
`endif
        while (ocupado && lat < 200) begin
            lat++;
            if (disparo != 0) begin
                if (pulse != 0 || !$onehot(disparo)) bad = 1;
                pulse = disparo; px = int'(tiro_X); py = int'(tiro_Y);
                rr_m = (rr_m + 1) % C;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset;
        reset = 1'b0; desc_m = 0; rr_m = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        int gap, lat, px, py, st; logic [1:0] pu; bit bad;
        reset = 1'b0; estado_jogo = 2'd1; enemy_vivos = '1; tiro_livre = 2'b11;
        desc_m = 0; rr_m = 0;
        #12;
        checks++; if (disparo !== 2'b00) begin errors++; $display("FAIL reset_disparo: got %b expected 00", disparo); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
        checks++; if (tiro_X !== 6'd0) begin errors++; $display("FAIL reset_tiro_X: got %0d expected 0", tiro_X); end
        checks++; if (tiro_Y !== 6'd0) begin errors++; $display("FAIL reset_tiro_Y: got %0d expected 0", tiro_Y); end
        checks++; if (descartes !== 16'd0) begin errors++; $display("FAIL reset_descartes: got %0d expected 0", descartes); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        observe(gap, lat, pu, px, py, st, bad);
        checks++; if (gap != P) begin errors++; $display("FAIL reset_first_gap: got %0d expected %0d", gap, P); end
    endtask

    task automatic test_all_alive;
        int gap, lat, px, py, st; logic [1:0] pu; bit bad;
        enemy_vivos = '1; tiro_livre = 2'b11;
        for (int i = 0; i < 3; i++) begin
            observe(gap, lat, pu, px, py, st, bad);
            checks++; if (gap != P) begin errors++; $display("FAIL alive_gap[%0d]: got %0d expected %0d", i, gap, P); end
            checks++; if (pu !== 2'b01) begin errors++; $display("FAIL alive_disparo[%0d]: got %b expected 01", i, pu); end
            checks++; if (py != L - 1) begin errors++; $display("FAIL alive_tiro_Y[%0d]: got %0d expected %0d", i, py, L - 1); end
            checks++; if (px != st) begin errors++; $display("FAIL alive_tiro_X[%0d]: got %0d expected %0d", i, px, st); end
            checks++; if (lat != 4) begin errors++; $display("FAIL alive_latency[%0d]: got %0d expected 4", i, lat); end
            checks++; if (bad) begin errors++; $display("FAIL alive_onehot[%0d]: got bad pulse expected clean", i); end
        end
    endtask

    task automatic test_random;
        int gap, lat, px, py, st, ex, ey, cells, elat; logic [1:0] pu, epu; bit bad, found;
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0: enemy_vivos = $urandom;
                1: enemy_vivos = $urandom & $urandom & $urandom;
                2: enemy_vivos = 32'd1 << $urandom_range(0, L * C - 1);
                default: enemy_vivos = '0;
            endcase
            tiro_livre = 2'($urandom_range(0, 3));
            observe(gap, lat, pu, px, py, st, bad);
            predict(st, enemy_vivos, found, ex, ey, cells);
            epu  = found ? first_free(tiro_livre) : 2'b00;
            elat = !found ? 1 + L * C : (tiro_livre != 0 ? cells + 3 : cells + 2);
            if (found && tiro_livre == 0) desc_m++;
            checks++; if (gap != P) begin errors++; $display("FAIL rnd_gap[%0d]: got %0d expected %0d", i, gap, P); end
            checks++; if (pu !== epu) begin errors++; $display("FAIL rnd_disparo[%0d]: got %b expected %b", i, pu, epu); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, elat); end
            checks++; if (descartes != 16'(desc_m)) begin errors++; $display("FAIL rnd_descartes[%0d]: got %0d expected %0d", i, descartes, desc_m); end
            checks++; if (bad) begin errors++; $display("FAIL rnd_onehot[%0d]: got bad pulse expected clean", i); end
            if (epu != 0) begin
                checks++; if (px != ex || py != ey) begin errors++; $display("FAIL rnd_xy[%0d]: got %0d,%0d expected %0d,%0d", i, px, py, ex, ey); end
            end
        end
    endtask

    task automatic test_empty;
        int gap, lat, px, py, st; logic [1:0] pu; bit bad;
        enemy_vivos = '0; tiro_livre = 2'b11;
        for (int i = 0; i < 10; i++) begin
            observe(gap, lat, pu, px, py, st, bad);
            checks++; if (pu !== 2'b00 || bad) begin errors++; $display("FAIL empty_disparo[%0d]: got %b expected 00", i, pu); end
            checks++; if (lat != 1 + L * C) begin errors++; $display("FAIL empty_busy[%0d]: got %0d expected %0d", i, lat, 1 + L * C); end
            checks++; if (gap != P) begin errors++; $display("FAIL empty_gap[%0d]: got %0d expected %0d", i, gap, P); end
        end
        checks++; if (descartes != 16'(desc_m)) begin errors++; $display("FAIL empty_descartes: got %0d expected %0d", descartes, desc_m); end
    endtask

    task automatic test_halt;
        int gap, lat, px, py, st, n, seen; logic [1:0] pu; bit bad;
        enemy_vivos = '0; tiro_livre = 2'b11; estado_jogo = 2'd1;
        n = 0;
        while (!ocupado && n < 100) begin @(negedge clk); n++; end
        checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL halt_start: got %b expected 1", ocupado); end
        repeat (2) @(negedge clk);
        estado_jogo = 2'd2;
        @(negedge clk);
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL halt_abort: got %b expected 0", ocupado); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ocupado || disparo != 0) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL halt_idle: got %0d busy cycles expected 0", seen); end
        enemy_vivos = '1; estado_jogo = 2'd1;
        observe(gap, lat, pu, px, py, st, bad);
        checks++; if (gap != P) begin errors++; $display("FAIL halt_resume_gap: got %0d expected %0d", gap, P); end
        checks++; if (pu !== 2'b01 || px != st) begin errors++; $display("FAIL halt_resume_pulse: got %b x=%0d expected 01 x=%0d", pu, px, st); end
        checks++; if (descartes != 16'(desc_m)) begin errors++; $display("FAIL halt_descartes: got %0d expected %0d", descartes, desc_m); end
    endtask

    task automatic test_single_enemy;
        int gap, lat, px, py, st, ex, ey, cells; logic [1:0] pu; bit bad, found;
        estado_jogo = 2'd1; tiro_livre = 2'b11; enemy_vivos = 32'd1 << 10;
        do_reset();
        observe(gap, lat, pu, px, py, st, bad);
        predict(st, enemy_vivos, found, ex, ey, cells);
        checks++; if (pu !== 2'b01) begin errors++; $display("FAIL single_disparo: got %b expected 01", pu); end
        checks++; if (px != 2 || py != 1) begin errors++; $display("FAIL single_xy: got %0d,%0d expected 2,1", px, py); end
        checks++; if (lat != cells + 3) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, cells + 3); end
`ifdef ESCALONADOR_RR_EN
        checks++; if (lat != 14) begin errors++; $display("FAIL single_rr_latency: got %0d expected 14", lat); end
`endif
    endtask

    task automatic test_no_slot;
        int gap, lat, px, py, st; logic [1:0] pu; bit bad;
        estado_jogo = 2'd1; enemy_vivos = '1; tiro_livre = 2'b00;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            observe(gap, lat, pu, px, py, st, bad);
            checks++; if (pu !== 2'b00 || lat != 3) begin errors++; $display("FAIL noslot_drop[%0d]: got %b busy=%0d expected 00 busy=3", i, pu, lat); end
        end
        checks++; if (descartes !== 16'd3) begin errors++; $display("FAIL noslot_descartes: got %0d expected 3", descartes); end
        tiro_livre = 2'b10;
        observe(gap, lat, pu, px, py, st, bad);
        checks++; if (pu !== 2'b10) begin errors++; $display("FAIL noslot_slot1: got %b expected 10", pu); end
        checks++; if (py != L - 1 || lat != 4) begin errors++; $display("FAIL noslot_slot1_y: got y=%0d busy=%0d expected y=%0d busy=4", py, lat, L - 1); end
    endtask

    task automatic test_reset_aloca;
        int gap, lat, px, py, st, n, seen; logic [1:0] pu; bit bad;
        enemy_vivos = '1; tiro_livre = 2'b11;
        n = 0;
        while (!ocupado && n < 100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL raloca_busy: got %b expected 1", ocupado); end
        reset = 1'b0; desc_m = 0; rr_m = 0;
        #1;
        checks++; if (disparo !== 2'b00 || ocupado !== 1'b0) begin errors++; $display("FAIL raloca_outputs: got %b/%b expected 00/0", disparo, ocupado); end
        checks++; if (tiro_X !== 6'd0 || tiro_Y !== 6'd0) begin errors++; $display("FAIL raloca_xy: got %0d,%0d expected 0,0", tiro_X, tiro_Y); end
        checks++; if (descartes !== 16'd0) begin errors++; $display("FAIL raloca_descartes: got %0d expected 0", descartes); end
        seen = 0;
        repeat (3) begin @(negedge clk); if (disparo != 0) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL raloca_no_pulse: got %0d pulses expected 0", seen); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        observe(gap, lat, pu, px, py, st, bad);
        checks++; if (gap != P) begin errors++; $display("FAIL raloca_gap: got %0d expected %0d", gap, P); end
        checks++; if (pu !== 2'b01 || lat != 4) begin errors++; $display("FAIL raloca_pulse: got %b busy=%0d expected 01 busy=4", pu, lat); end
    endtask

    initial begin
        test_reset();
        test_all_alive();
        test_random();
        test_empty();
        test_halt();
        test_single_enemy();
        test_no_slot();
        test_reset_aloca();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
